nts_engine_ctrl: RTL and testbench

Packet-lifecycle controller for the NTS engine. It is the parametrised successor to the engine's fixed copy/delay FSM. It sits between the dispatcher FIFO and the rx buffer / parser pair and copies one packet from the dispatcher into the buffer, enforcing minimum and maximum sizes. It then hands the packet to the parser through a start/done handshake guarded by a watchdog, reports the outcome, and releases the packet back to the dispatcher.

---
 rtl/nts_engine_ctrl_if.sv | 38 +++
 rtl/nts_engine_ctrl.sv | 150 +++++++++++++++
 tb/tb_nts_engine_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_engine_ctrl_if.sv
// Packet-lifecycle bus of the NTS engine controller.
// Groups the dispatcher FIFO, rx buffer / parser handshake and status lines.
//   master : the controller (drives o_* signals, samples i_* signals)
//   slave  : the surrounding engine (drives i_* signals, samples o_* signals)
// Parameter ADDR_WIDTH must match the controller instance (sizes o_word_count).
interface nts_engine_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  o_busy;
  logic                  i_dispatch_packet_available;
  logic                  i_dispatch_fifo_empty;
  logic                  o_dispatch_fifo_rd_en;
  logic                  o_dispatch_packet_read_discard;
  logic                  o_buffer_clear;
  logic                  o_parser_start;
  logic                  i_parser_done;
  logic                  i_parser_error;
  logic [3:0]            o_state;
  logic [ADDR_WIDTH:0]   o_word_count;
  logic [31:0]           o_packets_processed;
  logic [31:0]           o_packets_dropped;

  modport master (
    output o_busy, o_dispatch_fifo_rd_en, o_dispatch_packet_read_discard,
           o_buffer_clear, o_parser_start, o_state, o_word_count,
           o_packets_processed, o_packets_dropped,
    input  i_dispatch_packet_available, i_dispatch_fifo_empty,
           i_parser_done, i_parser_error
  );

  modport slave (
    input  o_busy, o_dispatch_fifo_rd_en, o_dispatch_packet_read_discard,
           o_buffer_clear, o_parser_start, o_state, o_word_count,
           o_packets_processed, o_packets_dropped,
    output i_dispatch_packet_available, i_dispatch_fifo_empty,
           i_parser_done, i_parser_error
  );
endinterface

// File: rtl/nts_engine_ctrl.sv
// nts_engine_ctrl: packet-lifecycle controller of the NTS engine.
// Copies one packet from the dispatcher FIFO into the rx buffer (enforcing
// MIN_WORDS .. 2**ADDR_WIDTH words), starts the parser, waits for done under a
// watchdog of TIMEOUT_CYCLES, then releases the packet with a discard pulse.
// Ports:
//   i_clk    : clock, all logic on the rising edge
//   i_areset : synchronous active-high reset
//   bus      : nts_engine_ctrl_if.master (dispatcher, buffer/parser, status)
// o_dispatch_fifo_rd_en and o_buffer_clear are combinational; all other
// outputs are registered.
// Optional feature: define NTS_ENGINE_CTRL_COUNTERS_EN to build the 32-bit
// processed/dropped packet counters; otherwise both outputs are tied to 0.
module nts_engine_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned MIN_WORDS      = 6,
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_areset,
  nts_engine_ctrl_if.master bus
);

  localparam int unsigned WC_W = ADDR_WIDTH + 1;
  localparam logic [WC_W-1:0] MAX_WORDS_W = WC_W'(1) << ADDR_WIDTH;
  localparam logic [WC_W-1:0] MIN_WORDS_W = WC_W'(MIN_WORDS);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_RESET      = 4'h0,
    ST_EMPTY      = 4'h1,
    ST_COPY       = 4'h2,
    ST_PROCESS    = 4'h3,
    ST_DONE       = 4'h4,
    ST_ERR_BAD    = 4'hC,
    ST_ERR_OVFL   = 4'hD,
    ST_ERR_GENERAL = 4'hE
  } state_t;

  state_t                   state_reg;
  state_t                   state_next;
  logic [WC_W-1:0]          word_count;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic                     busy_q;
  logic                     discard_q;
  logic                     start_q;
  logic                     rd_en_c;
  logic                     buffer_clear_c;
  logic                     terminal_next_c;

  // Next-state and combinational outputs
  always_comb begin
    state_next      = state_reg;
    rd_en_c         = 1'b0;
    buffer_clear_c  = 1'b0;
    terminal_next_c = 1'b0;
    case (state_reg)
      ST_RESET: begin
        buffer_clear_c = 1'b1;
        state_next     = ST_EMPTY;
      end
      ST_EMPTY: begin
        if (bus.i_dispatch_packet_available && !bus.i_dispatch_fifo_empty)
          state_next = ST_COPY;
      end
      ST_COPY: begin
        rd_en_c = !bus.i_dispatch_fifo_empty && (word_count < MAX_WORDS_W);
        // A full buffer with words still pending means the packet is too long.
        if (!bus.i_dispatch_fifo_empty && (word_count == MAX_WORDS_W))
          state_next = ST_ERR_OVFL;
        else if (bus.i_dispatch_fifo_empty)
          state_next = (word_count < MIN_WORDS_W) ? ST_ERR_BAD : ST_PROCESS;
      end
      ST_PROCESS: begin
        // Parser done takes priority over a watchdog expiring in the same cycle.
        if (bus.i_parser_done)
          state_next = bus.i_parser_error ? ST_ERR_BAD : ST_DONE;
        else if (timer == TIMER_LAST)
          state_next = ST_ERR_GENERAL;
      end
      ST_DONE, ST_ERR_BAD, ST_ERR_OVFL, ST_ERR_GENERAL: begin
        state_next = ST_RESET;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
    terminal_next_c = (state_next == ST_DONE)    || (state_next == ST_ERR_BAD) ||
                      (state_next == ST_ERR_OVFL) || (state_next == ST_ERR_GENERAL);
  end

  // State register, word counter, watchdog and registered pulses
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_reg  <= ST_RESET;
      word_count <= '0;
      timer      <= '0;
      busy_q     <= 1'b0;
      discard_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_q    <= (state_next != ST_RESET) && (state_next != ST_EMPTY);
      discard_q <= terminal_next_c;
      start_q   <= (state_reg == ST_COPY) && (state_next == ST_PROCESS);
      // rd_en only strobes below MAX_WORDS, so word_count saturates there.
      if (state_reg == ST_RESET)
        word_count <= '0;
      else if (rd_en_c)
        word_count <= word_count + WC_W'(1);
      if (state_reg == ST_RESET)
        timer <= '0;
      else if (state_reg == ST_PROCESS)
        timer <= timer + TIMEOUT_WIDTH'(1);
    end
  end

`ifdef NTS_ENGINE_CTRL_COUNTERS_EN
  logic [31:0] processed_q;
  logic [31:0] dropped_q;

  // Outcome counters, bumped on entry to the terminal state; wrap naturally
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      processed_q <= '0;
      dropped_q   <= '0;
    end else if (terminal_next_c) begin
      if (state_next == ST_DONE)
        processed_q <= processed_q + 32'd1;
      else
        dropped_q <= dropped_q + 32'd1;
    end
  end

  assign bus.o_packets_processed = processed_q;
  assign bus.o_packets_dropped   = dropped_q;
`else
  assign bus.o_packets_processed = '0;
  assign bus.o_packets_dropped   = '0;
`endif

  assign bus.o_busy                         = busy_q;
  assign bus.o_dispatch_fifo_rd_en          = rd_en_c;
  assign bus.o_dispatch_packet_read_discard = discard_q;
  assign bus.o_buffer_clear                 = buffer_clear_c;
  assign bus.o_parser_start                 = start_q;
  assign bus.o_state                        = state_reg;
  assign bus.o_word_count                   = word_count;

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Testbench for nts_engine_ctrl: drives packets through a dispatcher FIFO
// model and a parser model; a monitor checks each released packet against
// outcomes predicted from packet length and parser response.
module tb_nts_engine_ctrl;

  localparam int AW   = 4;
  localparam int MAXW = 1 << AW;
  localparam int MINW = 6;
  localparam int TW   = 16;
  localparam int TO   = 50;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  nts_engine_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  nts_engine_ctrl #(
    .ADDR_WIDTH(AW), .MIN_WORDS(MINW), .TIMEOUT_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_areset(areset),
    .bus(bus)
  );

  typedef struct {
    int st;
    int wc;
    int strobes;
    int starts;
    int processed;
    int dropped;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_resp = 0;

  // model state (stimulus side)
  int   m_proc = 0;
  int   m_drop = 0;
  int   fifo_cnt = 0;
  bit   avail = 0;
  int   done_delay = 0;
  bit   done_err = 0;
  int   proc_cyc = 0;
  bit   pdone = 0;
  bit   perr = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef NTS_ENGINE_CTRL_COUNTERS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Outcome of one packet from its length and the parser's reply.
  task automatic predict(input int len, input int d, input bit err, output exp_t e);
    e.strobes = (len > MAXW) ? MAXW : len;
    e.wc      = e.strobes;
    e.starts  = 0;
    if (len > MAXW)       e.st = 'hD;
    else if (len < MINW)  e.st = 'hC;
    else begin
      e.starts = 1;
      if (d >= 1 && d <= TO) e.st = err ? 'hC : 'h4;
      else                   e.st = 'hE;
    end
    if (e.st == 'h4) m_proc++;
    else             m_drop++;
    e.processed = exp_cnt(m_proc);
    e.dropped   = exp_cnt(m_drop);
  endtask

  task automatic drive();
    bus.i_dispatch_fifo_empty       = (fifo_cnt == 0);
    bus.i_dispatch_packet_available = avail;
    bus.i_parser_done               = pdone;
    bus.i_parser_error              = perr;
  endtask

  // One clock: sample strobes at negedge, update the models #1 after posedge.
  task automatic step();
    bit pop, disc;
    @(negedge clk);
    pop  = bus.o_dispatch_fifo_rd_en;
    disc = bus.o_dispatch_packet_read_discard;
    @(posedge clk);
    #1;
    if (pop && fifo_cnt > 0) fifo_cnt--;
    if (disc) begin
      fifo_cnt = 0;
      avail    = 0;
    end
    proc_cyc = (int'(bus.o_state) == 3) ? proc_cyc + 1 : 0;
    if (proc_cyc > 0) begin
      pdone = (proc_cyc == done_delay);
      perr  = done_err;
    end else begin
      // stray done pulses outside PROCESS must be ignored
      pdone = ($urandom_range(0, 7) == 0);
      perr  = $urandom_range(0, 1) == 1;
    end
    drive();
  endtask

  task automatic run_pkt(input int len, input int d, input bit err);
    exp_t e;
    int   target;
    predict(len, d, err, e);
    exp_q.push_back(e);
    target     = n_resp + 1;
    done_delay = d;
    done_err   = err;
    fifo_cnt   = len;
    avail      = 1;
    drive();
    for (int i = 0; i < 400 && n_resp < target; i++) step();
    chk("packet_completed", n_resp, target);
    if (n_resp < target) exp_q.delete();
  endtask

  // Monitor: pops an expectation on every discard pulse
  int   cyc_strobes = 0;
  int   cyc_starts = 0;
  int   post_phase = 0;
  exp_t pe;
  int   prev_state = 0;
  bit   prev_avail = 0;
  bit   prev_empty = 1;
  bit   prev_rst = 1;

  initial begin
    forever begin
      @(negedge clk);
      chk("buffer_clear_vs_state", int'(bus.o_buffer_clear), int'(bus.o_state == 4'h0));
      if (bus.o_dispatch_fifo_rd_en) cyc_strobes++;
      if (bus.o_parser_start) cyc_starts++;
      if (prev_state == 1 && prev_avail && !prev_empty && !prev_rst) begin
        chk("entry_state_copy", int'(bus.o_state), 2);
        chk("entry_rd_en", int'(bus.o_dispatch_fifo_rd_en), 1);
        chk("entry_busy", int'(bus.o_busy), 1);
      end
      if (post_phase == 1) begin
        chk("post_state_reset", int'(bus.o_state), 0);
        chk("post_busy", int'(bus.o_busy), 0);
        chk("post_discard_low", int'(bus.o_dispatch_packet_read_discard), 0);
        chk("post_processed", int'(bus.o_packets_processed), pe.processed);
        chk("post_dropped", int'(bus.o_packets_dropped), pe.dropped);
        post_phase = 2;
      end else if (post_phase == 2) begin
        chk("post_state_empty", int'(bus.o_state), 1);
        post_phase = 0;
        n_resp++;
      end
      if (bus.o_dispatch_packet_read_discard) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_discard: got discard with state %0d expected none", bus.o_state);
        end else begin
          pe = exp_q.pop_front();
          chk("term_state", int'(bus.o_state), pe.st);
          chk("term_word_count", int'(bus.o_word_count), pe.wc);
          chk("term_rd_strobes", cyc_strobes, pe.strobes);
          chk("term_parser_starts", cyc_starts, pe.starts);
          chk("term_busy", int'(bus.o_busy), 1);
          post_phase = 1;
        end
      end
      if (int'(bus.o_state) == 1) begin
        cyc_strobes = 0;
        cyc_starts  = 0;
      end
      prev_state = int'(bus.o_state);
      prev_avail = bus.i_dispatch_packet_available;
      prev_empty = bus.i_dispatch_fifo_empty;
      prev_rst   = areset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int len, d;
    bit err;
    areset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(bus.o_state), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_discard", int'(bus.o_dispatch_packet_read_discard), 0);
    chk("rst_parser_start", int'(bus.o_parser_start), 0);
    chk("rst_word_count", int'(bus.o_word_count), 0);
    chk("rst_processed", int'(bus.o_packets_processed), 0);
    chk("rst_dropped", int'(bus.o_packets_dropped), 0);
    chk("rst_buffer_clear", int'(bus.o_buffer_clear), 1);
    chk("rst_rd_en", int'(bus.o_dispatch_fifo_rd_en), 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    repeat (3) step();

    // directed: nominal, size limits, watchdog boundary, parser error
    run_pkt(10, 20, 0);
    run_pkt(4, 0, 0);
    run_pkt(MAXW + 1, 5, 0);
    run_pkt(MAXW, 3, 0);
    run_pkt(MINW, 1, 0);
    run_pkt(MINW - 1, 2, 0);
    run_pkt(10, 0, 0);
    run_pkt(10, TO, 0);
    run_pkt(10, TO + 1, 0);
    run_pkt(10, TO, 1);
    run_pkt(7, 2, 1);

    // reset in the middle of COPY after 3 words
    fifo_cnt   = 10;
    avail      = 1;
    done_delay = 5;
    done_err   = 0;
    drive();
    for (int i = 0; i < 50 && int'(bus.o_word_count) != 3; i++) step();
    chk("midrst_word_count_reached", int'(bus.o_word_count), 3);
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", int'(bus.o_state), 0);
    chk("midrst_buffer_clear", int'(bus.o_buffer_clear), 1);
    chk("midrst_discard", int'(bus.o_dispatch_packet_read_discard), 0);
    chk("midrst_busy", int'(bus.o_busy), 0);
    chk("midrst_processed", int'(bus.o_packets_processed), exp_cnt(m_proc));
    chk("midrst_dropped", int'(bus.o_packets_dropped), exp_cnt(m_drop));
    @(posedge clk);
    #1;
    areset   = 1'b0;
    fifo_cnt = 0;
    avail    = 0;
    proc_cyc = 0;
    pdone    = 0;
    drive();
    repeat (2) step();
    run_pkt(8, 10, 0);

    // randomized packets
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(1, MAXW + 4);
      d   = $urandom_range(0, TO + 10);
      err = ($urandom_range(0, 3) == 0);
      run_pkt(len, d, err);
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
